// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer.
// Holds the datapath-wide sizes, the opcode map, the run-mode encoding,
// the T-state bit indices and the micro-control word passed from the
// microcode decoder to the sequencer top.
package sap_pkg;

    localparam int NUM_T = 6;
    localparam int OPW   = 4;
    localparam int CNT_W = 8;

    localparam logic [OPW-1:0] OP_LDA = 4'b0000;
    localparam logic [OPW-1:0] OP_ADD = 4'b0001;
    localparam logic [OPW-1:0] OP_SUB = 4'b0010;
    localparam logic [OPW-1:0] OP_OUT = 4'b1110;
    localparam logic [OPW-1:0] OP_HLT = 4'b1111;

    // Bit positions inside the one-hot T-state ring.
    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;

    localparam logic [NUM_T-1:0] T_INIT  = {{(NUM_T-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_RUN,
        MODE_STEP,
        MODE_HALT
    } mode_t;

    // Raw microcode for the current phase. halt_req and undef are not
    // datapath signals; they tell the sequencer to stop or flag an error.
    typedef struct packed {
        logic pc_oe;
        logic ram_oe;
        logic ir_oe;
        logic a_oe;
        logic alu_oe;
        logic mar_ld;
        logic ir_ld;
        logic a_ld;
        logic b_ld;
        logic out_ld;
        logic pc_inc;
        logic alu_sub;
        logic halt_req;
        logic undef;
    } ctrl_t;

endpackage

// File: rtl/sap_sequencer_if.sv
// Control bundle between the sequencer and the datapath/front panel.
// master: sequencer side (takes tick_en/run/step/opcode, drives the
//         T-state, bus enables, load strobes and status).
// slave : datapath/front-panel side, the mirror image.
interface sap_sequencer_if;
    import sap_pkg::*;

    logic             tick_en;
    logic             run;
    logic             step;
    logic [OPW-1:0]   opcode;
    logic [NUM_T-1:0] t_state;
    logic             pc_oe;
    logic             ram_oe;
    logic             ir_oe;
    logic             a_oe;
    logic             alu_oe;
    logic             mar_ld;
    logic             ir_ld;
    logic             a_ld;
    logic             b_ld;
    logic             out_ld;
    logic             pc_inc;
    logic             alu_sub;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_cnt;
    logic             bus_busy;

    modport master (
        input  tick_en, run, step, opcode,
        output t_state, pc_oe, ram_oe, ir_oe, a_oe, alu_oe,
               mar_ld, ir_ld, a_ld, b_ld, out_ld, pc_inc, alu_sub,
               halted, illegal, instr_cnt, bus_busy
    );

    modport slave (
        output tick_en, run, step, opcode,
        input  t_state, pc_oe, ram_oe, ir_oe, a_oe, alu_oe,
               mar_ld, ir_ld, a_ld, b_ld, out_ld, pc_inc, alu_sub,
               halted, illegal, instr_cnt, bus_busy
    );

endinterface

// File: rtl/sap_microdecode.sv
// Purely combinational microcode ROM for the SAP CPU.
// Ports:
//   t_state : one-hot current phase
//   opcode  : IR upper nibble (only looked at in T3..T5)
//   ctrl    : raw control word, not yet gated by run mode or tick_en
module sap_microdecode
    import sap_pkg::*;
(
    input  logic [NUM_T-1:0] t_state,
    input  logic [OPW-1:0]   opcode,
    output ctrl_t            ctrl
);

    // Fetch phases T0..T2 are opcode-independent; execute phases decode
    // the opcode. Any opcode not listed leaves T3..T5 empty and raises
    // undef in T3 only, so the sticky flag is set once per instruction.
    always_comb begin
        ctrl = '0;
        if (t_state[T0]) begin
            ctrl.pc_oe  = 1'b1;
            ctrl.mar_ld = 1'b1;
        end
        if (t_state[T1]) begin
            ctrl.pc_inc = 1'b1;
        end
        if (t_state[T2]) begin
            ctrl.ram_oe = 1'b1;
            ctrl.ir_ld  = 1'b1;
        end
        if (t_state[T3]) begin
            case (opcode)
                OP_LDA, OP_ADD, OP_SUB: begin
                    ctrl.ir_oe  = 1'b1;
                    ctrl.mar_ld = 1'b1;
                end
                OP_OUT: begin
                    ctrl.a_oe   = 1'b1;
                    ctrl.out_ld = 1'b1;
                end
                OP_HLT:  ctrl.halt_req = 1'b1;
                default: ctrl.undef    = 1'b1;
            endcase
        end
        if (t_state[T4]) begin
            case (opcode)
                OP_LDA: begin
                    ctrl.ram_oe = 1'b1;
                    ctrl.a_ld   = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    ctrl.ram_oe = 1'b1;
                    ctrl.b_ld   = 1'b1;
                end
                default: ;
            endcase
        end
        if (t_state[T5]) begin
            case (opcode)
                OP_ADD: begin
                    ctrl.alu_oe = 1'b1;
                    ctrl.a_ld   = 1'b1;
                end
                OP_SUB: begin
                    ctrl.alu_oe  = 1'b1;
                    ctrl.a_ld    = 1'b1;
                    ctrl.alu_sub = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sap_sequencer.sv
// Run-mode controller and T-state sequencer for the SAP shared-bus CPU.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   seq      : master side of sap_sequencer_if
//              in : tick_en (phase advance), run (level), step (pulse), opcode
//              out: t_state, bus enables *_oe, load strobes, alu_sub,
//                   halted, illegal (sticky), instr_cnt (saturating), bus_busy
module sap_sequencer
    import sap_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    sap_sequencer_if.master seq
);

    mode_t            mode, mode_next;
    logic [NUM_T-1:0] t_cur, t_next;
    logic             illegal_q, illegal_next;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    ctrl_t            ctrl;
    logic             active;
    logic             gate;
    logic             adv;
    logic             retire;

    sap_microdecode u_decode (
        .t_state (t_cur),
        .opcode  (seq.opcode),
        .ctrl    (ctrl)
    );

    // Register bank for mode, ring position, sticky error and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= MODE_IDLE;
            t_cur     <= T_INIT;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            mode      <= mode_next;
            t_cur     <= t_next;
            illegal_q <= illegal_next;
            cnt_q     <= cnt_next;
        end
    end

    // Next-state logic. rst also masks gate/adv so that a reset arriving
    // mid-instruction cannot leak a strobe into the datapath that cycle.
    // An instruction retires at its T5 tick, or at the T3 tick of HLT.
    always_comb begin
        mode_next    = mode;
        t_next       = t_cur;
        illegal_next = illegal_q;
        cnt_next     = cnt_q;
        active       = (mode == MODE_RUN) || (mode == MODE_STEP);
        gate         = active && !rst;
        adv          = gate && seq.tick_en;
        retire       = adv && (t_cur[T5] || ctrl.halt_req);

        case (mode)
            MODE_IDLE: begin
                t_next = T_INIT;
                if (seq.run) begin
                    mode_next = MODE_RUN;
                end else if (seq.step) begin
                    mode_next = MODE_STEP;
                end
            end
            MODE_RUN, MODE_STEP: begin
                if (seq.tick_en) begin
                    if (ctrl.halt_req) begin
                        mode_next = MODE_HALT;
                        t_next    = T_INIT;
                    end else if (t_cur[T5]) begin
                        t_next = T_INIT;
                        if ((mode == MODE_STEP) || !seq.run) begin
                            mode_next = MODE_IDLE;
                        end
                    end else begin
                        t_next = {t_cur[NUM_T-2:0], t_cur[NUM_T-1]};
                    end
                end
            end
            MODE_HALT: begin
                t_next = T_INIT;
            end
            default: begin
                mode_next = MODE_IDLE;
                t_next    = T_INIT;
            end
        endcase

        if (adv && ctrl.undef) begin
            illegal_next = 1'b1;
        end
        if (retire && (cnt_q != CNT_MAX)) begin
            cnt_next = cnt_q + 1'b1;
        end
    end

    // Enables are levels for the whole phase; strobes only on the tick.
    assign seq.pc_oe   = gate && ctrl.pc_oe;
    assign seq.ram_oe  = gate && ctrl.ram_oe;
    assign seq.ir_oe   = gate && ctrl.ir_oe;
    assign seq.a_oe    = gate && ctrl.a_oe;
    assign seq.alu_oe  = gate && ctrl.alu_oe;
    assign seq.alu_sub = gate && ctrl.alu_sub;

    assign seq.mar_ld  = adv && ctrl.mar_ld;
    assign seq.ir_ld   = adv && ctrl.ir_ld;
    assign seq.a_ld    = adv && ctrl.a_ld;
    assign seq.b_ld    = adv && ctrl.b_ld;
    assign seq.out_ld  = adv && ctrl.out_ld;
    assign seq.pc_inc  = adv && ctrl.pc_inc;

    assign seq.bus_busy  = seq.pc_oe || seq.ram_oe || seq.ir_oe
                         || seq.a_oe || seq.alu_oe;
    assign seq.t_state   = t_cur;
    assign seq.halted    = (mode == MODE_HALT);
    assign seq.illegal   = illegal_q;
    assign seq.instr_cnt = cnt_q;

endmodule

// File: tb/tb_sap_sequencer.sv
// Directed self-checking bench for sap_sequencer.
// Walks LDA/ADD/SUB/OUT/HLT and an undefined opcode through run and step
// modes, checks every cycle against hand-written microcode tables, then
// covers mid-instruction reset and counter saturation.
module tb_sap_sequencer;
    import sap_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sap_sequencer_if sif ();

    sap_sequencer dut (
        .clk (clk),
        .rst (rst),
        .seq (sif)
    );

    // Observed bus enables {pc, ram, ir, a, alu} and strobes
    // {mar, pc_inc, ir, a, b, out}.
    wire [4:0] oe_obs  = {sif.pc_oe, sif.ram_oe, sif.ir_oe, sif.a_oe, sif.alu_oe};
    wire [5:0] stb_obs = {sif.mar_ld, sif.pc_inc, sif.ir_ld, sif.a_ld, sif.b_ld, sif.out_ld};

    localparam logic [4:0] E_PC  = 5'b10000;
    localparam logic [4:0] E_RAM = 5'b01000;
    localparam logic [4:0] E_IR  = 5'b00100;
    localparam logic [4:0] E_A   = 5'b00010;
    localparam logic [4:0] E_ALU = 5'b00001;

    localparam logic [5:0] S_MAR = 6'b100000;
    localparam logic [5:0] S_INC = 6'b010000;
    localparam logic [5:0] S_IR  = 6'b001000;
    localparam logic [5:0] S_A   = 6'b000100;
    localparam logic [5:0] S_B   = 6'b000010;
    localparam logic [5:0] S_OUT = 6'b000001;

    localparam logic [3:0] OP_BAD = 4'b0101;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt;
    logic exp_ill;

    logic [4:0] exp_oe  [6];
    logic [5:0] exp_stb [6];
    logic       exp_sub [6];

    // Count one comparison and report it if it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive all inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic t, input logic r, input logic s, input logic [3:0] op);
        sif.tick_en = t;
        sif.run     = r;
        sif.step    = s;
        sif.opcode  = op;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, OP_LDA);
        nextCycle();
        nextCycle();
        rst     = 1'b0;
        exp_cnt = 0;
        exp_ill = 1'b0;
    endtask

    // Hand-written microcode table for one opcode.
    task automatic loadTables(input logic [3:0] op);
        for (int i = 0; i < 6; i++) begin
            exp_oe[i]  = '0;
            exp_stb[i] = '0;
            exp_sub[i] = 1'b0;
        end
        exp_oe[0] = E_PC;  exp_stb[0] = S_MAR;
        exp_stb[1] = S_INC;
        exp_oe[2] = E_RAM; exp_stb[2] = S_IR;
        case (op)
            OP_LDA: begin
                exp_oe[3] = E_IR;  exp_stb[3] = S_MAR;
                exp_oe[4] = E_RAM; exp_stb[4] = S_A;
            end
            OP_ADD: begin
                exp_oe[3] = E_IR;  exp_stb[3] = S_MAR;
                exp_oe[4] = E_RAM; exp_stb[4] = S_B;
                exp_oe[5] = E_ALU; exp_stb[5] = S_A;
            end
            OP_SUB: begin
                exp_oe[3] = E_IR;  exp_stb[3] = S_MAR;
                exp_oe[4] = E_RAM; exp_stb[4] = S_B;
                exp_oe[5] = E_ALU; exp_stb[5] = S_A;
                exp_sub[5] = 1'b1;
            end
            OP_OUT: begin
                exp_oe[3] = E_A;   exp_stb[3] = S_OUT;
            end
            default: ;
        endcase
    endtask

    // Run nphases phases of 4 clocks each, tick on the 4th clock.
    // run is held high for phases below drop_phase; opcode carries junk
    // during fetch to show it is ignored there.
    task automatic runInstr(input logic [3:0] op, input int nphases, input int drop_phase,
                            input logic step_mid, input string name);
        logic       tk, rv, sv;
        logic [3:0] opv;
        loadTables(op);
        for (int p = 0; p < nphases; p++) begin
            for (int c = 0; c < 4; c++) begin
                tk  = (c == 3);
                rv  = (p < drop_phase);
                sv  = step_mid && (p == 2) && (c == 1);
                opv = (p >= 3) ? op : OP_BAD;
                applyStimulus(tk, rv, sv, opv);
                checkOutput($sformatf("%s t_state p%0d c%0d", name, p, c), 32'(sif.t_state), 32'(1 << p));
                checkOutput($sformatf("%s oe p%0d c%0d", name, p, c), 32'(oe_obs), 32'(exp_oe[p]));
                checkOutput($sformatf("%s strobes p%0d c%0d", name, p, c), 32'(stb_obs),
                            tk ? 32'(exp_stb[p]) : 32'd0);
                checkOutput($sformatf("%s alu_sub p%0d c%0d", name, p, c), 32'(sif.alu_sub), 32'(exp_sub[p]));
                checkOutput($sformatf("%s bus_busy p%0d c%0d", name, p, c), 32'(sif.bus_busy),
                            32'(exp_oe[p] != 5'd0));
                checkOutput($sformatf("%s one_oe p%0d c%0d", name, p, c), 32'($countones(oe_obs) <= 1), 32'd1);
                checkOutput($sformatf("%s halted p%0d c%0d", name, p, c), 32'(sif.halted), 32'd0);
                checkOutput($sformatf("%s illegal p%0d c%0d", name, p, c), 32'(sif.illegal), 32'(exp_ill));
                checkOutput($sformatf("%s instr_cnt p%0d c%0d", name, p, c), 32'(sif.instr_cnt), 32'(exp_cnt));
                nextCycle();
                if (tk) begin
                    if ((p == 3) && !(op inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT})) exp_ill = 1'b1;
                    if ((p == 5) || ((p == 3) && (op == OP_HLT))) exp_cnt++;
                end
            end
        end
    endtask

    // In IDLE a tick must neither move the ring nor produce any output.
    task automatic checkIdle(input string name);
        applyStimulus(1'b1, 1'b0, 1'b0, OP_LDA);
        checkOutput({name, " idle t_state"}, 32'(sif.t_state), 32'd1);
        checkOutput({name, " idle oe"}, 32'(oe_obs), 32'd0);
        checkOutput({name, " idle strobes"}, 32'(stb_obs), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, OP_LDA);
        checkOutput({name, " idle t_state held"}, 32'(sif.t_state), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        doReset();

        $display("[TB] reset state");
        applyStimulus(1'b0, 1'b0, 1'b0, OP_LDA);
        checkOutput("reset t_state", 32'(sif.t_state), 32'd1);
        checkOutput("reset oe", 32'(oe_obs), 32'd0);
        checkOutput("reset strobes", 32'(stb_obs), 32'd0);
        checkOutput("reset halted", 32'(sif.halted), 32'd0);
        checkOutput("reset illegal", 32'(sif.illegal), 32'd0);
        checkOutput("reset instr_cnt", 32'(sif.instr_cnt), 32'd0);
        checkOutput("reset bus_busy", 32'(sif.bus_busy), 32'd0);

        $display("[TB] LDA in run mode");
        applyStimulus(1'b1, 1'b1, 1'b0, OP_LDA);
        checkOutput("idle tick oe", 32'(oe_obs), 32'd0);
        checkOutput("idle tick strobes", 32'(stb_obs), 32'd0);
        nextCycle();
        runInstr(OP_LDA, 6, 5, 1'b0, "lda");
        checkOutput("lda instr_cnt", 32'(sif.instr_cnt), 32'd1);
        checkIdle("lda");

        $display("[TB] SUB then ADD");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, OP_SUB);
        nextCycle();
        runInstr(OP_SUB, 6, 6, 1'b0, "sub");
        runInstr(OP_ADD, 6, 5, 1'b0, "add");
        checkOutput("add instr_cnt", 32'(sif.instr_cnt), 32'd2);
        checkIdle("add");

        $display("[TB] single-step OUT");
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, OP_OUT);
        nextCycle();
        runInstr(OP_OUT, 6, 0, 1'b1, "out");
        checkOutput("out instr_cnt", 32'(sif.instr_cnt), 32'd1);
        checkIdle("out");

        $display("[TB] HLT");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, OP_HLT);
        nextCycle();
        runInstr(OP_HLT, 4, 6, 1'b0, "hlt");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, i[0] ? OP_LDA : OP_HLT);
            checkOutput($sformatf("halt halted %0d", i), 32'(sif.halted), 32'd1);
            checkOutput($sformatf("halt t_state %0d", i), 32'(sif.t_state), 32'd1);
            checkOutput($sformatf("halt oe %0d", i), 32'(oe_obs), 32'd0);
            checkOutput($sformatf("halt strobes %0d", i), 32'(stb_obs), 32'd0);
            checkOutput($sformatf("halt alu_sub %0d", i), 32'(sif.alu_sub), 32'd0);
            checkOutput($sformatf("halt instr_cnt %0d", i), 32'(sif.instr_cnt), 32'd1);
            nextCycle();
        end
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, OP_LDA);
        checkOutput("halt cleared by rst", 32'(sif.halted), 32'd0);
        checkOutput("halt rst instr_cnt", 32'(sif.instr_cnt), 32'd0);

        $display("[TB] undefined opcode");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, OP_LDA);
        nextCycle();
        runInstr(OP_BAD, 6, 6, 1'b0, "undef");
        runInstr(OP_LDA, 6, 5, 1'b0, "lda_after_undef");
        checkOutput("illegal sticky", 32'(sif.illegal), 32'd1);
        checkOutput("undef instr_cnt", 32'(sif.instr_cnt), 32'd2);
        checkIdle("lda_after_undef");

        $display("[TB] drop run at T2");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, OP_LDA);
        nextCycle();
        runInstr(OP_LDA, 6, 2, 1'b0, "drop");
        checkOutput("drop instr_cnt", 32'(sif.instr_cnt), 32'd1);
        checkIdle("drop");

        $display("[TB] reset at T4");
        applyStimulus(1'b0, 1'b1, 1'b0, OP_ADD);
        nextCycle();
        runInstr(OP_ADD, 4, 6, 1'b0, "rstmid");
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, OP_ADD);
        checkOutput("rst T4 strobes", 32'(stb_obs), 32'd0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, OP_ADD);
        checkOutput("rst T4 t_state", 32'(sif.t_state), 32'd1);
        checkOutput("rst T4 instr_cnt", 32'(sif.instr_cnt), 32'd0);
        checkOutput("rst T4 oe", 32'(oe_obs), 32'd0);

        $display("[TB] counter saturation");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, OP_LDA);
        nextCycle();
        for (int i = 0; i < 255 * 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, OP_LDA);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, OP_LDA);
        checkOutput("sat reach 255", 32'(sif.instr_cnt), 32'd255);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, OP_LDA);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, OP_LDA);
        checkOutput("sat hold 255", 32'(sif.instr_cnt), 32'd255);
        checkOutput("sat t_state", 32'(sif.t_state), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
